// File: rtl/pn_pkg.sv
// Shared constants and the 5-bit PN step used by the arbiter and its generator core.
package pn_pkg;
  localparam int            PN_W    = 5;
  localparam logic [PN_W-1:0] PN_SEED = 5'h1f;

  // Lower taps feed off the freshly computed upper bits, so order matters.
  function automatic logic [PN_W-1:0] pn5_next(input logic [PN_W-1:0] s);
    logic [PN_W-1:0] n;
    n[4] = s[4] ^ s[1];
    n[3] = s[3] ^ s[0];
    n[2] = s[2] ^ n[4];
    n[1] = s[1] ^ n[3];
    n[0] = s[0] ^ n[2];
    return n;
  endfunction
endpackage

// File: rtl/pn5_core.sv
// PN generator state register: load wins over advance, otherwise the word is held.
module pn5_core
  import pn_pkg::*;
#(
  parameter logic [PN_W-1:0] SEED = PN_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [PN_W-1:0] load_val_i,
  input  logic            adv_i,
  output logic [PN_W-1:0] state_o
);
  logic [PN_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i)     state_d = load_val_i;
    else if (adv_i) state_d = pn5_next(state_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;
endmodule

// File: rtl/pn_share_arbiter.sv
// Round-robin share of one PN generator: each grant issues the current word and steps it.
module pn_share_arbiter
  import pn_pkg::*;
#(
  parameter int              NREQ = 4,
  parameter logic [PN_W-1:0] SEED = PN_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            hold,
  input  logic            seed_load,
  input  logic [PN_W-1:0] seed_val,
  output logic [NREQ-1:0] gnt,
  output logic [PN_W-1:0] data_out,
  output logic            data_vld,
  output logic            data_sync
);
  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [PN_W-1:0]  pn_state, seed_eff;
  logic [PN_W-1:0]  start_q, start_d, data_q, data_d;
  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             vld_q, vld_d, sync_q, sync_d;
  logic             any_req, grant_en;

  // An all-zero seed would lock the generator up, so it falls back to SEED.
  assign seed_eff = (seed_val == '0) ? SEED : seed_val;

  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  assign grant_en = !seed_load && !hold && any_req;

  always_comb begin
    gnt_d   = '0;
    vld_d   = 1'b0;
    sync_d  = 1'b0;
    data_d  = data_q;
    ptr_d   = ptr_q;
    start_d = seed_load ? seed_eff : start_q;
    if (grant_en) begin
      gnt_d  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
      vld_d  = 1'b1;
      sync_d = (pn_state == start_q);
      data_d = pn_state;
      ptr_d  = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      sync_q  <= 1'b0;
      data_q  <= '0;
      ptr_q   <= PTR_W'(NREQ - 1);
      start_q <= SEED;
    end else begin
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
    end
  end

  pn5_core #(.SEED(SEED)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (seed_load),
    .load_val_i(seed_eff),
    .adv_i     (grant_en),
    .state_o   (pn_state)
  );

  assign gnt       = gnt_q;
  assign data_out  = data_q;
  assign data_vld  = vld_q;
  assign data_sync = sync_q;
endmodule
